// File: rtl/qspi_xfer_ctrl.sv
// qspi_xfer_ctrl: sequences one QSPI flash read per request.
// The one-time 0xB7 (enter 4-byte address) frame comes first when needed,
// followed by the command, address, dummy and data phases. Every phase is
// steered through datapath loads, enables, IO selects, counter limits and
// SCLK gating.
// Optional feature: define QSPI_XFER_CTRL_TIMEOUT_EN to add a per-phase
// watchdog (TIMEOUT_CYCLES). Without it, a phase waits for count_done_in
// indefinitely.
module qspi_xfer_ctrl #(
  parameter int CS_GAP_CYCLES = 2  // must be >= 1
`ifdef QSPI_XFER_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024  // must be >= 2
`endif
) (
  input  logic       h_clk,
  input  logic       h_rst,
  input  logic       req_in,
  output logic       ack_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       err_out,
  input  logic       addr_of_4B_in,
  input  logic       use_1_io_lines_in,
  input  logic       use_2_io_lines_in,
  input  logic       use_4_io_lines_in,
  input  logic       count_done_in,
  output logic       cs_n_out,
  output logic       gen_sclk_out,
  output logic       load_cfg_addr_shift_reg_out,
  output logic       cfg_addr_shift_reg_en_out,
  output logic       load_cmd_out,
  output logic       cmd_shift_reg_en_out,
  output logic [1:0] cmd_sel_out,
  output logic       load_addr_out,
  output logic       addr_shift_reg_en_out,
  output logic       data_sample_reg_en_out,
  output logic       start_count_out,
  output logic [1:0] set_count_lim_out,
  output logic [2:0] io0_sel_out,
  output logic [1:0] io1_sel_out,
  output logic [1:0] io2_sel_out,
  output logic [1:0] io3_sel_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_LOAD, S_CFG_SHIFT, S_CS_GAP, S_CMD_LOAD, S_CMD_SHIFT,
    S_ADDR_SHIFT, S_DUMMY, S_DATA, S_DONE, S_ERR
  } state_t;

  localparam int GAP_W = (CS_GAP_CYCLES > 1) ? $clog2(CS_GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP_CYCLES - 1);

`ifdef QSPI_XFER_CTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            waiting;
`endif

  state_t           state_q, state_d;
  logic             b4_done_q, b4_done_d;
  // first_q marks the opening cycle of ADDR/DUMMY/DATA, where the counter
  // start pulse is issued and a stale count_done_in must be ignored.
  logic             first_q, first_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             mode_1io_q, mode_1io_d;
  logic             mode_4b_q, mode_4b_d;
  logic             accept;
  logic             phase_done;
  logic             quad;
  logic             unused_mode;

  // Dual mode is rejected by the absence of single/quad, so the dual decode
  // itself carries no extra information.
  assign unused_mode = use_2_io_lines_in;

  assign accept     = req_in && !h_rst;
  assign phase_done = count_done_in && !first_q;
  assign quad       = !mode_1io_q;
  assign busy_out   = (state_q != S_IDLE);

  // Control state: FSM, 4-byte-mode flag, phase bookkeeping counters.
  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      state_q   <= S_IDLE;
      b4_done_q <= 1'b0;
      first_q   <= 1'b0;
      gap_cnt_q <= '0;
`ifdef QSPI_XFER_CTRL_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      b4_done_q <= b4_done_d;
      first_q   <= first_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef QSPI_XFER_CTRL_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  // Mode latch: captured at acceptance, only meaningful while busy.
  always_ff @(posedge h_clk) begin
    mode_1io_q <= mode_1io_d;
    mode_4b_q  <= mode_4b_d;
  end

  // Next-state and datapath steering for each state.
  always_comb begin
    state_d    = state_q;
    b4_done_d  = b4_done_q;
    first_d    = 1'b0;
    gap_cnt_d  = gap_cnt_q;
    mode_1io_d = mode_1io_q;
    mode_4b_d  = mode_4b_q;

    ack_out                     = 1'b0;
    done_out                    = 1'b0;
    err_out                     = 1'b0;
    cs_n_out                    = 1'b1;
    gen_sclk_out                = 1'b0;
    load_cfg_addr_shift_reg_out = 1'b0;
    cfg_addr_shift_reg_en_out   = 1'b0;
    load_cmd_out                = 1'b0;
    cmd_shift_reg_en_out        = 1'b0;
    cmd_sel_out                 = 2'b00;
    load_addr_out               = 1'b0;
    addr_shift_reg_en_out       = 1'b0;
    data_sample_reg_en_out      = 1'b0;
    start_count_out             = 1'b0;
    set_count_lim_out           = 2'b00;
    io0_sel_out                 = 3'b000;
    io1_sel_out                 = 2'b00;
    io2_sel_out                 = 2'b00;
    io3_sel_out                 = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ack_out    = 1'b1;
          mode_1io_d = use_1_io_lines_in;
          mode_4b_d  = addr_of_4B_in;
          if (!use_1_io_lines_in && !use_4_io_lines_in) begin
            state_d = S_ERR;
          end else if (addr_of_4B_in && !b4_done_q) begin
            state_d = S_CFG_LOAD;
          end else begin
            state_d = S_CMD_LOAD;
          end
        end
      end

      // CS drops in the load cycle so the gap after the 0xB7 frame is
      // exactly CS_GAP_CYCLES and CS leads the first SCLK by one cycle.
      S_CFG_LOAD: begin
        cs_n_out                    = 1'b0;
        load_cfg_addr_shift_reg_out = 1'b1;
        start_count_out             = 1'b1;
        set_count_lim_out           = 2'b00;
        state_d                     = S_CFG_SHIFT;
      end

      S_CFG_SHIFT: begin
        cs_n_out                  = 1'b0;
        gen_sclk_out              = 1'b1;
        cfg_addr_shift_reg_en_out = 1'b1;
        io0_sel_out               = 3'b001;
        if (phase_done) begin
          b4_done_d = 1'b1;
          gap_cnt_d = '0;
          state_d   = S_CS_GAP;
        end
      end

      S_CS_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_CMD_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      S_CMD_LOAD: begin
        cs_n_out          = 1'b0;
        load_cmd_out      = 1'b1;
        load_addr_out     = 1'b1;
        cmd_sel_out       = {~mode_4b_q, mode_1io_q};
        start_count_out   = 1'b1;
        set_count_lim_out = 2'b00;
        state_d           = S_CMD_SHIFT;
      end

      S_CMD_SHIFT: begin
        cs_n_out             = 1'b0;
        gen_sclk_out         = 1'b1;
        cmd_shift_reg_en_out = 1'b1;
        io0_sel_out          = 3'b010;
        if (phase_done) begin
          first_d = 1'b1;
          state_d = S_ADDR_SHIFT;
        end
      end

      S_ADDR_SHIFT: begin
        cs_n_out              = 1'b0;
        gen_sclk_out          = 1'b1;
        addr_shift_reg_en_out = 1'b1;
        start_count_out       = first_q;
        set_count_lim_out     = 2'b01;
        io0_sel_out           = 3'b011;
        if (quad) begin
          io1_sel_out = 2'b01;
          io2_sel_out = 2'b01;
          io3_sel_out = 2'b01;
        end
        if (phase_done) begin
          first_d = 1'b1;
          state_d = quad ? S_DUMMY : S_DATA;
        end
      end

      S_DUMMY: begin
        cs_n_out          = 1'b0;
        gen_sclk_out      = 1'b1;
        start_count_out   = first_q;
        set_count_lim_out = 2'b10;
        if (phase_done) begin
          first_d = 1'b1;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        cs_n_out               = 1'b0;
        gen_sclk_out           = 1'b1;
        data_sample_reg_en_out = 1'b1;
        start_count_out        = first_q;
        set_count_lim_out      = 2'b11;
        if (quad) begin
          io0_sel_out = 3'b100;
          io1_sel_out = 2'b10;
          io2_sel_out = 2'b10;
          io3_sel_out = 2'b10;
        end else begin
          io1_sel_out = 2'b10;
        end
        if (phase_done) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end

      S_ERR: begin
        err_out = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef QSPI_XFER_CTRL_TIMEOUT_EN
    // Watchdog: restarts on every phase change, trips while a phase stalls.
    waiting  = (state_q == S_CFG_SHIFT) || (state_q == S_CMD_SHIFT) ||
               (state_q == S_ADDR_SHIFT) || (state_q == S_DUMMY) ||
               (state_q == S_DATA);
    to_cnt_d = '0;
    if (waiting && (state_d == state_q)) begin
      if (to_cnt_q == TO_LAST) begin
        state_d = S_ERR;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif
  end

endmodule
